// File: rtl/adc_scan_scheduler_if.sv
// Bundle of the scan scheduler's control, SPI and result-stream signals.
// master: the scheduler side.  slave: the side that drives control/ADC/consumer.
// With ADC_DIFF_EN defined the bundle also carries diff_mask [7:0].
interface adc_scan_scheduler_if;
  logic       start;
  logic       cont;
  logic [7:0] ch_en;
`ifdef ADC_DIFF_EN
  logic [7:0] diff_mask;
`endif
  logic       AD_CLK;
  logic       CS;
  logic       DIN;
  logic       DOUT;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_ch;
  logic [9:0] res_data;
  logic       busy;

`ifdef ADC_DIFF_EN
  modport master (
    input  start, cont, ch_en, diff_mask, DOUT, res_ready,
    output AD_CLK, CS, DIN, res_valid, res_ch, res_data, busy
  );
  modport slave (
    output start, cont, ch_en, diff_mask, DOUT, res_ready,
    input  AD_CLK, CS, DIN, res_valid, res_ch, res_data, busy
  );
`else
  modport master (
    input  start, cont, ch_en, DOUT, res_ready,
    output AD_CLK, CS, DIN, res_valid, res_ch, res_data, busy
  );
  modport slave (
    output start, cont, ch_en, DOUT, res_ready,
    input  AD_CLK, CS, DIN, res_valid, res_ch, res_data, busy
  );
`endif
endinterface

// File: rtl/adc_scan_scheduler.sv
// Round-robin scan scheduler for an 8-channel 10-bit SPI ADC.
// Each frame: CS low for one setup half period, 17 AD_CLK bits
// (start, SGL, D2..D0, sample, null, B9..B0), then CS high for CS_GAP half
// periods while the result is offered on a valid/ready stream.
// Optional macro ADC_DIFF_EN adds diff_mask: SGL = ~diff_mask[ch]; otherwise SGL=1.
module adc_scan_scheduler #(
  parameter int unsigned CLK_DIV = 27,  // clk cycles per AD_CLK half period
  parameter int unsigned CS_GAP  = 2    // half periods of CS high between frames
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_scan_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_WAIT_ACK
  } state_t;

  // 17 bits, each a high half followed by a low half.
  localparam logic [11:0] DIV_LAST   = 12'(CLK_DIV - 1);
  localparam logic [5:0]  SHIFT_LAST = 6'd33;
  localparam logic [5:0]  GAP_LAST   = 6'(CS_GAP - 1);

  state_t      r_state;
  logic [11:0] r_div_cnt;
  logic [5:0]  r_half;        // half-period index within SHIFT or HOLD
  logic [2:0]  r_ptr;         // last channel started; round-robin search begins above it
  logic [2:0]  r_cur_ch;
  logic [7:0]  r_remaining;   // channels of the current pass not yet converted
  logic [4:0]  r_cmd;         // command bits still to send, MSB is on DIN
  logic [9:0]  r_shift;       // DOUT history; last ten rising edges are B9..B0
  logic        r_adclk;
  logic        r_cs;
  logic        r_res_valid;
  logic [2:0]  r_res_ch;
  logic [9:0]  r_res_data;
  logic        r_busy;

  logic        w_tick;
  logic        w_timed;
  logic        w_ack_done;
  logic        w_launch;
  logic [7:0]  w_cand;
  logic [2:0]  w_sel_ch;
  logic        w_sgl;

  // Lowest set bit of mask strictly above last, wrapping 7 -> 0.
  function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] last);
    logic [2:0] c;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      c = last + 3'(i);
      if (!found && mask[c]) begin
        rr_pick = c;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign w_timed    = (r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD);
  assign w_ack_done = !r_res_valid || bus.res_ready;
  assign w_sel_ch   = rr_pick(w_cand, r_ptr);

`ifdef ADC_DIFF_EN
  assign w_sgl = ~bus.diff_mask[w_sel_ch];
`else
  assign w_sgl = 1'b1;
`endif

  // Decide whether a frame starts now and which channels it may pick from.
  always_comb begin
    // NOTE: defaults first so no path leaves these unassigned (no latch).
    w_launch = 1'b0;
    w_cand   = 8'd0;
    case (r_state)
      S_IDLE: begin
        if ((bus.start || bus.cont) && (bus.ch_en != 8'd0)) begin
          w_launch = 1'b1;
          w_cand   = bus.ch_en;
        end
      end
      S_WAIT_ACK: begin
        if (w_ack_done && (bus.ch_en != 8'd0)) begin
          if ((r_remaining & bus.ch_en) != 8'd0) begin
            w_launch = 1'b1;
            w_cand   = r_remaining & bus.ch_en;
          end else if (bus.cont) begin
            w_launch = 1'b1;
            w_cand   = bus.ch_en;
          end
        end
      end
      default: ;
    endcase
  end

  // Half-period divider: runs only while a frame or CS gap is being timed.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_div_cnt <= 12'd0;
    end else if (w_timed && !w_tick) begin
      r_div_cnt <= r_div_cnt + 12'd1;
    end else begin
      r_div_cnt <= 12'd0;
    end
  end

  // Frame sequencer with registered SPI, result and busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_half      <= 6'd0;
      r_ptr       <= 3'd7;
      r_cur_ch    <= 3'd0;
      r_remaining <= 8'd0;
      r_cmd       <= 5'd0;
      r_shift     <= 10'd0;
      r_adclk     <= 1'b0;
      r_cs        <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_ch    <= 3'd0;
      r_res_data  <= 10'd0;
      r_busy      <= 1'b0;
    end else begin
      if (r_res_valid && bus.res_ready) r_res_valid <= 1'b0;

      case (r_state)
        S_IDLE, S_WAIT_ACK: begin
          if (w_launch) begin
            r_state     <= S_SETUP;
            r_busy      <= 1'b1;
            r_cs        <= 1'b0;
            r_adclk     <= 1'b0;
            r_half      <= 6'd0;
            r_cur_ch    <= w_sel_ch;
            r_ptr       <= w_sel_ch;
            r_remaining <= w_cand & ~(8'd1 << w_sel_ch);
            r_cmd       <= {1'b1, w_sgl, w_sel_ch};
          end else if ((r_state == S_WAIT_ACK) && w_ack_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        S_SETUP: begin
          if (w_tick) begin
            r_state <= S_SHIFT;
            r_half  <= 6'd0;
            r_adclk <= 1'b1;
            r_shift <= {r_shift[8:0], bus.DOUT};
          end
        end

        S_SHIFT: begin
          if (w_tick) begin
            if (r_half == SHIFT_LAST) begin
              r_state <= S_HOLD;
              r_half  <= 6'd0;
              r_cs    <= 1'b1;
            end else begin
              r_half  <= r_half + 6'd1;
              r_adclk <= ~r_adclk;
              // DIN advances on falling edges; DOUT is captured on rising edges.
              if (r_adclk) r_cmd   <= {r_cmd[3:0], 1'b0};
              else         r_shift <= {r_shift[8:0], bus.DOUT};
            end
          end
        end

        S_HOLD: begin
          // First cycle after HOLD entry: present the finished conversion.
          if ((r_half == 6'd0) && (r_div_cnt == 12'd0)) begin
            r_res_valid <= 1'b1;
            r_res_ch    <= r_cur_ch;
            r_res_data  <= r_shift;
          end
          if (w_tick) begin
            if (r_half == GAP_LAST) begin
              r_state <= S_WAIT_ACK;
              r_half  <= 6'd0;
            end else begin
              r_half <= r_half + 6'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cs    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.AD_CLK    = r_adclk;
  assign bus.CS        = r_cs;
  assign bus.DIN       = r_cmd[4];
  assign bus.res_valid = r_res_valid;
  assign bus.res_ch    = r_res_ch;
  assign bus.res_data  = r_res_data;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Self-checking bench for adc_scan_scheduler: behavioural ADC on the SPI pins,
// result scoreboard filled at stimulus time and drained by a stream monitor.
module tb_adc_scan_scheduler;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CS_GAP  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adc_scan_scheduler_if bus();

  adc_scan_scheduler #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ch;
    logic [9:0] data;
  } res_t;

  res_t       sb[$];
  int         n_checks  = 0;
  int         n_pass    = 0;
  int         n_results = 0;

  // ADC model state
  logic [9:0] adc_code [8];
  int         rise_cnt   = 0;
  int         last_rises = 0;
  logic [4:0] cmd_bits   = 5'd0;
  logic [4:0] last_cmd   = 5'd0;
  logic [2:0] model_ch   = 3'd0;
  logic [1:0] stuck_mode = 2'd0;  // 0 normal, 1 DOUT stuck high, 2 stuck low

  function automatic res_t mk(input logic [2:0] ch, input logic [9:0] data);
    res_t r;
    r.ch   = ch;
    r.data = data;
    return r;
  endfunction

  // ADC: record command bits on AD_CLK rises; CS rising closes the frame.
  always @(posedge bus.AD_CLK or posedge bus.CS) begin
    if (bus.CS) begin
      last_rises = rise_cnt;
      last_cmd   = cmd_bits;
      rise_cnt   = 0;
      cmd_bits   = 5'd0;
    end else begin
      if (rise_cnt < 5) cmd_bits = {cmd_bits[3:0], bus.DIN};
      if (rise_cnt == 4) model_ch = cmd_bits[2:0];
      rise_cnt = rise_cnt + 1;
    end
  end

  // ADC: present the next data bit after each falling AD_CLK edge.
  always @(negedge bus.AD_CLK) begin
    int idx;
    idx = 16 - rise_cnt;
    if (stuck_mode == 2'd1)      bus.DOUT = 1'b1;
    else if (stuck_mode == 2'd2) bus.DOUT = 1'b0;
    else if (!bus.CS && rise_cnt >= 7 && rise_cnt <= 16) bus.DOUT = adc_code[model_ch][idx[3:0]];
    else bus.DOUT = 1'b0;
  end

  // Result stream monitor: every accepted result is popped from the scoreboard.
  always @(negedge clk) begin
    res_t got;
    res_t exp_r;
    if (!rst && bus.res_valid && bus.res_ready) begin
      got.ch   = bus.res_ch;
      got.data = bus.res_data;
      n_results++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL result_unexpected: got ch=%0d data=%h, required no result", got.ch, got.data);
      end else begin
        exp_r = sb.pop_front();
        if (got !== exp_r)
          $display("FAIL result_%0d: got ch=%0d data=%h, required ch=%0d data=%h",
                   n_results, got.ch, got.data, exp_r.ch, exp_r.data);
        else
          n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    int k;
    k = 0;
    while ((bus.busy || sb.size() != 0) && k < max_cyc) begin
      tick(1);
      k++;
    end
    ok = !bus.busy && (sb.size() == 0);
  endtask

  task automatic test_reset();
    bit bad;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.cont      = 1'b0;
    bus.ch_en     = 8'h01;
    bus.res_ready = 1'b1;
    bus.DOUT      = 1'b0;
`ifdef ADC_DIFF_EN
    bus.diff_mask = 8'h00;
`endif
    tick(3);
    n_checks++; if (bus.CS !== 1'b1)        $display("FAIL reset_cs: got %b, required 1", bus.CS); else n_pass++;
    n_checks++; if (bus.AD_CLK !== 1'b0)    $display("FAIL reset_adclk: got %b, required 0", bus.AD_CLK); else n_pass++;
    n_checks++; if (bus.DIN !== 1'b0)       $display("FAIL reset_din: got %b, required 0", bus.DIN); else n_pass++;
    n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", bus.res_valid); else n_pass++;
    n_checks++;
    if ({bus.res_ch, bus.res_data} !== 13'd0)
      $display("FAIL reset_result: got ch=%0d data=%h, required 0/000", bus.res_ch, bus.res_data);
    else n_pass++;
    n_checks++; if (bus.busy !== 1'b0)      $display("FAIL reset_busy: got %b, required 0", bus.busy); else n_pass++;
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      tick(1);
      if (bus.CS !== 1'b1 || bus.busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL idle_without_start: got a frame, required CS high/busy low");
    else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    bus.ch_en     = 8'h01;
    bus.res_ready = 1'b1;
    adc_code[0]   = 10'h2A5;
    sb.push_back(mk(3'd0, 10'h2A5));
    pulse_start();
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b, required 1", bus.busy); else n_pass++;
    wait_done(2000, ok);
    n_checks++; if (!ok) $display("FAIL single_done: got busy=%b pending=%0d, required 0/0", bus.busy, sb.size()); else n_pass++;
    n_checks++; if (last_rises != 17) $display("FAIL single_edges: got %0d, required 17", last_rises); else n_pass++;
    n_checks++; if (last_cmd !== 5'b11000) $display("FAIL single_cmd: got %b, required 11000", last_cmd); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    int order [3] = '{2, 5, 7};
    bus.ch_en     = 8'hA4;
    bus.cont      = 1'b0;
    bus.res_ready = 1'b1;
    foreach (order[i]) sb.push_back(mk(3'(order[i]), adc_code[order[i]]));
    pulse_start();
    wait_done(4000, ok);
    n_checks++; if (!ok) $display("FAIL rr_done: got busy=%b pending=%0d, required 0/0", bus.busy, sb.size()); else n_pass++;
  endtask

  task automatic test_cont();
    bit ok;
    int base;
    int k;
    int order [4] = '{0, 7, 0, 7};
    bus.ch_en     = 8'h81;
    bus.res_ready = 1'b1;
    base          = n_results;
    foreach (order[i]) sb.push_back(mk(3'(order[i]), adc_code[order[i]]));
    bus.cont = 1'b1;
    k = 0;
    while (n_results < base + 3 && k < 4000) begin
      tick(1);
      k++;
    end
    bus.cont = 1'b0;
    n_checks++; if (n_results < base + 3) $display("FAIL cont_third: got %0d results, required 3", n_results - base); else n_pass++;
    wait_done(2000, ok);
    n_checks++; if (!ok) $display("FAIL cont_done: got busy=%b pending=%0d, required 0/0", bus.busy, sb.size()); else n_pass++;
    tick(200);
    n_checks++;
    if (bus.busy !== 1'b0 || n_results != base + 4)
      $display("FAIL cont_stop: got busy=%b results=%0d, required 0/4", bus.busy, n_results - base);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit bad;
    int k;
    logic [9:0] held;
    bus.ch_en     = 8'h06;
    bus.res_ready = 1'b0;
    sb.push_back(mk(3'd1, adc_code[1]));
    sb.push_back(mk(3'd2, adc_code[2]));
    pulse_start();
    k = 0;
    while (bus.res_valid !== 1'b1 && k < 500) begin
      tick(1);
      k++;
    end
    n_checks++; if (bus.res_valid !== 1'b1) $display("FAIL bp_valid: got %b, required 1", bus.res_valid); else n_pass++;
    held = bus.res_data;
    bad  = 1'b0;
    repeat (100) begin
      tick(1);
      if (bus.res_valid !== 1'b1 || bus.res_data !== held || bus.CS !== 1'b1 || bus.busy !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL bp_stall: got change during stall (data=%h CS=%b), required held %h, CS 1", bus.res_data, bus.CS, held);
    else n_pass++;
    bus.res_ready = 1'b1;
    wait_done(2000, ok);
    n_checks++; if (!ok) $display("FAIL bp_done: got busy=%b pending=%0d, required 0/0", bus.busy, sb.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit bad;
    int k;
    bus.ch_en     = 8'h01;
    bus.res_ready = 1'b1;
    pulse_start();
    k = 0;
    while (rise_cnt < 10 && k < 500) begin
      tick(1);
      k++;
    end
    n_checks++; if (rise_cnt < 10) $display("FAIL mid_reach: got %0d edges, required 10", rise_cnt); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.CS !== 1'b1)        $display("FAIL mid_cs: got %b, required 1", bus.CS); else n_pass++;
    n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL mid_valid: got %b, required 0", bus.res_valid); else n_pass++;
    tick(2);
    rst = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      tick(1);
      if (bus.res_valid !== 1'b0 || bus.CS !== 1'b1) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL mid_partial: got activity after abort, required none"); else n_pass++;
    adc_code[0] = 10'h13C;
    sb.push_back(mk(3'd0, 10'h13C));
    pulse_start();
    wait_done(2000, ok);
    n_checks++; if (!ok) $display("FAIL mid_restart: got busy=%b pending=%0d, required 0/0", bus.busy, sb.size()); else n_pass++;
  endtask

  task automatic test_stuck();
    bit ok;
    bus.ch_en = 8'h01;
    for (int v = 1; v >= 0; v--) begin
      stuck_mode = (v == 1) ? 2'd1 : 2'd2;
      bus.DOUT   = (v == 1);
      sb.push_back(mk(3'd0, (v == 1) ? 10'h3FF : 10'h000));
      pulse_start();
      wait_done(2000, ok);
      n_checks++;
      if (!ok) $display("FAIL stuck_%0d_done: got busy=%b pending=%0d, required 0/0", v, bus.busy, sb.size());
      else n_pass++;
    end
    stuck_mode = 2'd0;
  endtask

  task automatic test_sgl();
    bit ok;
    logic [4:0] exp_cmd;
`ifdef ADC_DIFF_EN
    bus.diff_mask = 8'h08;
    exp_cmd       = 5'b10011;
`else
    exp_cmd       = 5'b11011;
`endif
    bus.ch_en = 8'h08;
    sb.push_back(mk(3'd3, adc_code[3]));
    pulse_start();
    wait_done(2000, ok);
    n_checks++; if (!ok) $display("FAIL sgl_done: got busy=%b pending=%0d, required 0/0", bus.busy, sb.size()); else n_pass++;
    n_checks++; if (last_cmd !== exp_cmd) $display("FAIL sgl_cmd: got %b, required %b", last_cmd, exp_cmd); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) adc_code[i] = 10'(32'h3A7 - i * 73);
    test_reset();
    test_single();
    test_round_robin();
    test_cont();
    test_backpressure();
    test_reset_mid();
    test_stuck();
    test_sgl();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
